// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot_product design.
// State encoding plus the accumulator width rule.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int acc_width(input int width, input int length);
    return 2 * width + $clog2(length);
  endfunction

endpackage

// File: rtl/dot_product_serial_ripple_adder.sv
// N-bit ripple carry adder.
// A plain chain of full_adder cells.
module ripple_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic [N:0] c;

  assign c[0] = carry_in;

  for (genvar k = 0; k < N; k++) begin : g_fa
    full_adder u_fa (
      .a   (a[k]),
      .b   (b[k]),
      .cin (c[k]),
      .sum (sum[k]),
      .cout(c[k+1])
    );
  end

  assign carry_out = c[N];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Building block of the ripple carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/dot_product_serial.sv
// Bit-serial unsigned dot-product engine.
// One shift-and-add step per cycle, LENGTH elements per result.
module dot_product_serial
  import dot_product_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LENGTH    = 4,
  parameter int ACC_WIDTH = acc_width(WIDTH, LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(LENGTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [IW-1:0]        i;
  logic [CW-1:0]        elem_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;

  always_comb begin
    addend = '0;
    if (b_reg[i])
      addend = ACC_WIDTH'(a_reg) << i;
  end

  ripple_adder #(
    .N(ACC_WIDTH)
  ) u_add (
    .a        (acc),
    .b        (addend),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out(carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      i        <= '0;
      elem_cnt <= '0;
      acc      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            i     <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc <= sum;
          if (i == I_LAST) begin
            i <= '0;
            if (elem_cnt == C_LAST) begin
              state <= DONE;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
              state    <= IDLE;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc      <= '0;
            elem_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc;

  // ACC_WIDTH is sized so the sum can never carry out.
  assert property (@(posedge clk) disable iff (!rst_n) !carry);

endmodule

// File: tb/tb_dot_product_serial.sv
// Randomized bench for dot_product_serial against a cycle-level model.
// Two instances: WIDTH=8/LENGTH=4 and WIDTH=4/LENGTH=1.
module tb_dot_product_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[2];
  logic        ir[2];
  logic        ov[2];
  logic        ordy[2];
  logic [7:0]  av[2];
  logic [7:0]  bv[2];
  logic [17:0] r8;
  logic [7:0]  r4;

  int tests = 0;
  int fails = 0;

  longint m_sum[2];
  int     m_cnt[2];
  int     m_busy[2];
  bit     m_done[2];

  always #5 clk = ~clk;

  dot_product_serial #(.WIDTH(8), .LENGTH(4)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv[0]),
    .in_ready (ir[0]),
    .a_in     (av[0]),
    .b_in     (bv[0]),
    .out_valid(ov[0]),
    .out_ready(ordy[0]),
    .result   (r8)
  );

  dot_product_serial #(.WIDTH(4), .LENGTH(1)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv[1]),
    .in_ready (ir[1]),
    .a_in     (av[1][3:0]),
    .b_in     (bv[1][3:0]),
    .out_valid(ov[1]),
    .out_ready(ordy[1]),
    .result   (r4)
  );

  function automatic int wd(int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic int ln(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic longint res(int d);
    return (d == 0) ? longint'(r8) : longint'(r4);
  endfunction

  function automatic int msk(int d);
    return (d == 0) ? 255 : 15;
  endfunction

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted element costs WIDTH cycles; the LENGTH-th ends in done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_sum[d]  <= 0;
        m_cnt[d]  <= 0;
        m_busy[d] <= 0;
        m_done[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_done[d]) begin
          if (ordy[d]) begin
            m_done[d] <= 1'b0;
            m_sum[d]  <= 0;
            m_cnt[d]  <= 0;
          end
        end else if (m_busy[d] == 0) begin
          if (iv[d]) begin
            m_sum[d]  <= m_sum[d] + longint'(av[d] & msk(d)) * longint'(bv[d] & msk(d));
            m_cnt[d]  <= m_cnt[d] + 1;
            m_busy[d] <= wd(d);
          end
        end else begin
          m_busy[d] <= m_busy[d] - 1;
          if (m_busy[d] == 1 && m_cnt[d] == ln(d))
            m_done[d] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("in_ready[%0d]", d), longint'(ir[d]),
              longint'(!m_done[d] && m_busy[d] == 0));
        check($sformatf("out_valid[%0d]", d), longint'(ov[d]), longint'(m_done[d]));
        if (m_done[d])
          check($sformatf("result[%0d]", d), res(d), m_sum[d]);
      end
    end
  end

  task automatic send(int d, int a, int b);
    int t = 0;
    @(negedge clk);
    while (!ir[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ir[d]) begin
      check("send timeout", 0, 1);
      return;
    end
    iv[d] = 1'b1;
    av[d] = 8'(a);
    bv[d] = 8'(b);
    @(negedge clk);
    iv[d] = 1'b0;
    av[d] = 8'($urandom & msk(d));
    bv[d] = 8'($urandom & msk(d));
  endtask

  task automatic get(int d, longint exp, string name);
    int lat = 0;
    while (!ov[d] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, wd(d));
    check({name, " result"}, res(d), exp);
  endtask

  task automatic take(int d);
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    check("out_valid after take", longint'(ov[d]), 0);
    check("in_ready after take", longint'(ir[d]), 1);
  endtask

  initial begin
    int a_q[4];
    int b_q[4];
    longint exp;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
      av[d]   = '0;
      bv[d]   = '0;
    end
    repeat (2) @(negedge clk);
    check("reset in_ready", longint'(ir[0]), 1);
    check("reset out_valid", longint'(ov[0]), 0);
    check("reset result", res(0), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) send(0, k + 1, k + 5);
    get(0, 70, "basic");
    check("model basic sum", m_sum[0], 70);

    for (int k = 0; k < 5; k++) begin
      iv[0] = 1'b1;
      av[0] = 8'($urandom);
      bv[0] = 8'($urandom);
      @(negedge clk);
      check("hold result", res(0), 70);
      check("hold out_valid", longint'(ov[0]), 1);
      check("hold in_ready", longint'(ir[0]), 0);
    end
    iv[0] = 1'b0;
    take(0);

    for (int k = 0; k < 4; k++) send(0, 1, 1);
    get(0, 4, "ones");
    take(0);

    for (int k = 0; k < 4; k++) send(0, 255, 255);
    get(0, 260100, "max");
    check("model max sum", m_sum[0], 260100);
    take(0);

    send(0, 9, 9);
    send(0, 7, 3);
    send(0, 200, 100);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset in_ready", longint'(ir[0]), 1);
    check("async reset out_valid", longint'(ov[0]), 0);
    check("async reset result", res(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 2, 3);
    for (int k = 0; k < 3; k++) send(0, 0, 0);
    get(0, 6, "after reset");
    take(0);

    send(1, 15, 15);
    get(1, 225, "len1 max");
    take(1);

    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 15; r++) begin
        exp = 0;
        for (int k = 0; k < ln(d); k++) begin
          a_q[k] = int'($urandom & msk(d));
          b_q[k] = int'($urandom & msk(d));
          if ($urandom_range(0, 3) == 0) b_q[k] = 0;
          exp += longint'(a_q[k]) * longint'(b_q[k]);
        end
        for (int k = 0; k < ln(d); k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(d, a_q[k], b_q[k]);
        end
        get(d, exp, "random");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        take(d);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
